multicycle_control_fsm: RTL and testbench

Multi-cycle control unit for the sequential RV64 core. It sequences the shared datapath (PC, IR, register file, immediate generator, ALU, unified memory port) through fetch, decode, execute, memory and write-back for ld, sd, beq and R-type instructions. It owns the memory handshake, including a wait-state watchdog, and a retired-instruction counter. Unsupported opcodes and memory timeouts halt the core.

---
 rtl/multicycle_control_fsm.sv | 145 ++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control unit for the sequential RV64 core: sequences fetch, decode,
// execute, memory and write-back for ld, sd, beq and R-type, with a memory watchdog.
module multicycle_control_fsm #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             halted,
    output logic             illegal_op,
    output logic             bus_err,
    output logic [CNT_W-1:0] retired
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, ADDR, MEM_RD, LD_WB, MEM_WR, R_EX, R_WB, BRANCH, HALT
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              in_mem;

    assign in_mem = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            retired    <= '0;
            illegal_op <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            wait_cnt <= '0;
            // Stalled requests are handled here; the case below only sees completions.
            if (in_mem && !mem_ready) begin
                if (wait_cnt == WAIT_LAST) begin
                    state   <= HALT;
                    bus_err <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end
            unique case (state)
                IDLE:   state <= FETCH;
                FETCH:  if (mem_ready) state <= DECODE;
                DECODE: begin
                    if (opcode == OP_LD || opcode == OP_SD) state <= ADDR;
                    else if (opcode == OP_R)                state <= R_EX;
                    else if (opcode == OP_BEQ)              state <= BRANCH;
                    else begin
                        state      <= HALT;
                        illegal_op <= 1'b1;
                    end
                end
                ADDR:   state <= (opcode == OP_LD) ? MEM_RD : MEM_WR;
                MEM_RD: if (mem_ready) state <= LD_WB;
                MEM_WR: begin
                    if (mem_ready) begin
                        retired <= retired + 1'b1;
                        state   <= FETCH;
                    end
                end
                LD_WB, R_WB, BRANCH: begin
                    retired <= retired + 1'b1;
                    state   <= FETCH;
                end
                R_EX:   state <= R_WB;
                HALT:   state <= HALT;
                default: state <= HALT;
            endcase
        end
    end

    // Datapath controls are forced low while reset is held so an aborted
    // instruction cannot write the PC, IR or register file on the reset edge.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        alu_src_b    = 1'b0;
        alu_op       = 2'b00;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;
        halted       = (state == HALT);
        if (rst_n) begin
            unique case (state)
                FETCH: begin
                    mem_req  = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                ADDR:   alu_src_b = 1'b1;
                MEM_RD: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                end
                LD_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                MEM_WR: begin
                    mem_req      = 1'b1;
                    mem_we       = 1'b1;
                    mem_addr_sel = 1'b1;
                end
                R_EX:   alu_op = 2'b10;
                R_WB: begin
                    alu_op    = 2'b10;
                    reg_write = 1'b1;
                end
                BRANCH: begin
                    alu_op   = 2'b01;
                    pc_write = zero;
                    pc_src   = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: a default instance and a small one
// (TIMEOUT=4, CNT_W=3) share stimulus; each cycle checks outputs and retire counts.
module tb_multicycle_control_fsm;

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_ILL = 7'b0010011;

    // {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, alu_src_b,
    //  alu_op[1:0], reg_write, mem_to_reg, halted, illegal_op, bus_err}
    localparam logic [13:0] O_NONE  = 14'h0000;
    localparam logic [13:0] O_FWAIT = 14'h2000;
    localparam logic [13:0] O_FRDY  = 14'h2600;
    localparam logic [13:0] O_ADDR  = 14'h0080;
    localparam logic [13:0] O_MEMRD = 14'h2800;
    localparam logic [13:0] O_LDWB  = 14'h0018;
    localparam logic [13:0] O_MEMWR = 14'h3800;
    localparam logic [13:0] O_REX   = 14'h0040;
    localparam logic [13:0] O_RWB   = 14'h0050;
    localparam logic [13:0] O_BRT   = 14'h0320;
    localparam logic [13:0] O_BRN   = 14'h0120;
    localparam logic [13:0] O_HILL  = 14'h0006;
    localparam logic [13:0] O_HBUS  = 14'h0005;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic        mem_req0, mem_we0, mem_addr_sel0, ir_write0, pc_write0, pc_src0;
    logic        alu_src_b0, reg_write0, mem_to_reg0, halted0, illegal_op0, bus_err0;
    logic [1:0]  alu_op0;
    logic [31:0] retired0;
    logic        mem_req1, mem_we1, mem_addr_sel1, ir_write1, pc_write1, pc_src1;
    logic        alu_src_b1, reg_write1, mem_to_reg1, halted1, illegal_op1, bus_err1;
    logic [1:0]  alu_op1;
    logic [2:0]  retired1;
    logic [13:0] out0, out1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm u_dut0 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req0), .mem_we(mem_we0), .mem_addr_sel(mem_addr_sel0),
        .ir_write(ir_write0), .pc_write(pc_write0), .pc_src(pc_src0),
        .alu_src_b(alu_src_b0), .alu_op(alu_op0), .reg_write(reg_write0),
        .mem_to_reg(mem_to_reg0), .halted(halted0), .illegal_op(illegal_op0),
        .bus_err(bus_err0), .retired(retired0)
    );

    multicycle_control_fsm #(.TIMEOUT(4), .CNT_W(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr_sel(mem_addr_sel1),
        .ir_write(ir_write1), .pc_write(pc_write1), .pc_src(pc_src1),
        .alu_src_b(alu_src_b1), .alu_op(alu_op1), .reg_write(reg_write1),
        .mem_to_reg(mem_to_reg1), .halted(halted1), .illegal_op(illegal_op1),
        .bus_err(bus_err1), .retired(retired1)
    );

    assign out0 = {mem_req0, mem_we0, mem_addr_sel0, ir_write0, pc_write0, pc_src0,
                   alu_src_b0, alu_op0, reg_write0, mem_to_reg0, halted0, illegal_op0, bus_err0};
    assign out1 = {mem_req1, mem_we1, mem_addr_sel1, ir_write1, pc_write1, pc_src1,
                   alu_src_b1, alu_op1, reg_write1, mem_to_reg1, halted1, illegal_op1, bus_err1};

    typedef struct {
        string       nm;
        logic        r;
        logic [6:0]  op;
        logic        z;
        logic        rdy;
        logic [13:0] e;
        logic [31:0] ret;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input logic r, input logic [6:0] op, input logic z,
                       input logic rdy, input logic [13:0] e, input logic [31:0] ret);
        vec_t v;
        v.nm = nm; v.r = r; v.op = op; v.z = z; v.rdy = rdy; v.e = e; v.ret = ret;
        vecs.push_back(v);
    endtask

    // One clock cycle: drive inputs after the falling edge, check before the rising edge.
    task automatic step(input string nm, input logic r, input logic [6:0] op, input logic z,
                        input logic rdy, input logic [13:0] e0, input logic [13:0] e1,
                        input logic [31:0] r0, input logic [2:0] r1);
        @(negedge clk);
        rst_n = r; opcode = op; zero = z; mem_ready = rdy;
        #1;
        checks += 4;
        if (out0 !== e0) begin
            errors++;
            $display("FAIL %s dut0 outputs: got %h want %h", nm, out0, e0);
        end
        if (retired0 !== r0) begin
            errors++;
            $display("FAIL %s dut0 retired: got %0d want %0d", nm, retired0, r0);
        end
        if (out1 !== e1) begin
            errors++;
            $display("FAIL %s dut1 outputs: got %h want %h", nm, out1, e1);
        end
        if (retired1 !== r1) begin
            errors++;
            $display("FAIL %s dut1 retired: got %0d want %0d", nm, retired1, r1);
        end
    endtask

    initial begin
        rst_n = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk);

        add("rst0", 0, '0, 0, 0, O_NONE, 0);
        add("rst1", 0, '0, 0, 1, O_NONE, 0);
        add("rst2", 0, '0, 0, 0, O_NONE, 0);
        add("idle", 1, '0, 0, 0, O_NONE, 0);
        add("ld_fetch",  1, OP_LD, 0, 1, O_FRDY,  0);
        add("ld_decode", 1, OP_LD, 0, 1, O_NONE,  0);
        add("ld_addr",   1, OP_LD, 0, 0, O_ADDR,  0);
        add("ld_memrd",  1, OP_LD, 0, 1, O_MEMRD, 0);
        add("ld_wb",     1, OP_LD, 0, 0, O_LDWB,  0);
        add("sd_fetch",  1, OP_SD, 0, 1, O_FRDY,  1);
        add("sd_decode", 1, OP_SD, 0, 0, O_NONE,  1);
        add("sd_addr",   1, OP_SD, 0, 0, O_ADDR,  1);
        add("sd_wait1",  1, OP_SD, 0, 0, O_MEMWR, 1);
        add("sd_wait2",  1, OP_SD, 0, 0, O_MEMWR, 1);
        add("sd_wait3",  1, OP_SD, 0, 0, O_MEMWR, 1);
        add("sd_done",   1, OP_SD, 0, 1, O_MEMWR, 1);
        add("beqt_fetch",  1, OP_BEQ, 0, 1, O_FRDY, 2);
        add("beqt_decode", 1, OP_BEQ, 1, 0, O_NONE, 2);
        add("beqt_branch", 1, OP_BEQ, 1, 0, O_BRT,  2);
        add("beqn_fetch",  1, OP_BEQ, 1, 1, O_FRDY, 3);
        add("beqn_decode", 1, OP_BEQ, 0, 0, O_NONE, 3);
        add("beqn_branch", 1, OP_BEQ, 0, 0, O_BRN,  3);
        add("r_fetch",   1, OP_R, 0, 1, O_FRDY, 4);
        add("r_decode",  1, OP_R, 0, 0, O_NONE, 4);
        add("r_ex",      1, OP_R, 1, 0, O_REX,  4);
        add("r_wb",      1, OP_R, 0, 0, O_RWB,  4);
        add("ill_fetch",  1, OP_ILL, 0, 1, O_FRDY, 5);
        add("ill_decode", 1, OP_ILL, 0, 0, O_NONE, 5);
        add("ill_halt",   1, OP_ILL, 0, 1, O_HILL, 5);
        add("ill_halt2",  1, OP_ILL, 0, 0, O_HILL, 5);
        add("ill_rst",    0, OP_ILL, 0, 0, O_HILL, 5);
        add("ill_idle",   1, '0,     0, 0, O_NONE, 0);

        foreach (vecs[i])
            step(vecs[i].nm, vecs[i].r, vecs[i].op, vecs[i].z, vecs[i].rdy,
                 vecs[i].e, vecs[i].e, vecs[i].ret, vecs[i].ret[2:0]);

        // Fetch that never completes: small instance halts after 4, default after 16.
        for (int i = 1; i <= 17; i++)
            step($sformatf("timeout_%0d", i), 1, '0, 0, 0,
                 (i <= 16) ? O_FWAIT : O_HBUS, (i <= 4) ? O_FWAIT : O_HBUS, 0, 0);
        step("bus_rst",  0, '0, 0, 0, O_HBUS, O_HBUS, 0, 0);
        step("bus_idle", 1, '0, 0, 0, O_NONE, O_NONE, 0, 0);

        // Reset during LD_WB: no register write, no retire.
        step("abort_fetch",  1, OP_LD, 0, 1, O_FRDY,  O_FRDY,  0, 0);
        step("abort_decode", 1, OP_LD, 0, 0, O_NONE,  O_NONE,  0, 0);
        step("abort_addr",   1, OP_LD, 0, 0, O_ADDR,  O_ADDR,  0, 0);
        step("abort_memrd",  1, OP_LD, 0, 1, O_MEMRD, O_MEMRD, 0, 0);
        step("abort_wb_rst", 0, OP_LD, 0, 0, O_NONE,  O_NONE,  0, 0);
        step("abort_idle",   1, OP_LD, 0, 0, O_NONE,  O_NONE,  0, 0);

        // Nine back-to-back R-types: the 3-bit counter wraps to 1.
        for (int k = 0; k < 9; k++) begin
            step($sformatf("wrap%0d_fetch", k),  1, OP_R, 0, 1, O_FRDY, O_FRDY, k, 3'(k));
            step($sformatf("wrap%0d_decode", k), 1, OP_R, 0, 0, O_NONE, O_NONE, k, 3'(k));
            step($sformatf("wrap%0d_ex", k),     1, OP_R, 0, 0, O_REX,  O_REX,  k, 3'(k));
            step($sformatf("wrap%0d_wb", k),     1, OP_R, 0, 0, O_RWB,  O_RWB,  k, 3'(k));
        end
        step("wrap_end", 1, OP_R, 0, 0, O_FWAIT, O_FWAIT, 9, 3'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
